nibble_packer_4: RTL and testbench

- Producer side of the 16-bit NIBBLES bus consumed by the max-nibble selection blocks.
- Accepts a serial stream of 4-bit nibbles (valid/ready) and packs every 4 accepted nibbles into one 16-bit word, presented with valid/ready.
- Alongside each word it also presents the running maximum nibble, computed sequentially, as a cross-check for the parallel comparator tree downstream.
- A one-word pending buffer lets packing of the next word complete while the output is stalled.

---
 rtl/nibble_packer_4.sv | 127 ++++++++++++
 tb/tb_nibble_packer_4.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_packer_4.sv
// Serial nibble to 16-bit word packer with running max.
// One-word pending buffer absorbs a completed word during output stall.
module nibble_packer_4 #(
  parameter int COUNT_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               IN_VALID,
  input  logic [3:0]         IN_NIBBLE,
  output logic               IN_READY,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [15:0]        NIBBLES,
  output logic [3:0]         NIBBLE_MAYOR,
  output logic [COUNT_W-1:0] WORD_COUNT
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [1:0]         slot, slot_n;
  logic [11:0]        part, part_n;
  logic [3:0]         pmax, pmax_n;
  logic [15:0]        pend_w, pend_w_n;
  logic [3:0]         pend_m, pend_m_n;
  logic               out_v, out_v_n;
  logic [15:0]        out_w, out_w_n;
  logic [3:0]         out_m, out_m_n;
  logic [COUNT_W-1:0] cnt, cnt_n;

  logic               in_xfer;
  logic               out_xfer;
  logic               done;
  logic [3:0]         nib_max;

  // Ready depends on registered state only (and reset).
  assign IN_READY     = (state == FILL) && !RESET;
  assign OUT_VALID    = out_v;
  assign NIBBLES      = out_w;
  assign NIBBLE_MAYOR = out_m;
  assign WORD_COUNT   = cnt;

  // Next-state: packing, word completion, output hand-off.
  always_comb begin
    state_n  = state;
    slot_n   = slot;
    part_n   = part;
    pmax_n   = pmax;
    pend_w_n = pend_w;
    pend_m_n = pend_m;
    out_v_n  = out_v;
    out_w_n  = out_w;
    out_m_n  = out_m;
    cnt_n    = cnt;

    in_xfer  = IN_VALID && (state == FILL);
    out_xfer = out_v && OUT_READY;
    done     = in_xfer && (slot == 2'd3);
    nib_max  = (IN_NIBBLE > pmax) ? IN_NIBBLE : pmax;

    if (out_xfer) begin
      out_v_n = 1'b0;
      cnt_n   = cnt + 1'b1;
    end

    if (in_xfer) begin
      slot_n = slot + 2'd1;
      pmax_n = (slot == 2'd0) ? IN_NIBBLE : nib_max;
      unique case (slot)
        2'd0: part_n[3:0]  = IN_NIBBLE;
        2'd1: part_n[7:4]  = IN_NIBBLE;
        2'd2: part_n[11:8] = IN_NIBBLE;
        2'd3: ;
      endcase
    end

    if (done) begin
      if (!out_v || OUT_READY) begin
        out_w_n = {IN_NIBBLE, part};
        out_m_n = nib_max;
        out_v_n = 1'b1;
      end else begin
        pend_w_n = {IN_NIBBLE, part};
        pend_m_n = nib_max;
        state_n  = FULL;
      end
    end

    if ((state == FULL) && out_xfer) begin
      out_w_n = pend_w;
      out_m_n = pend_m;
      out_v_n = 1'b1;
      state_n = FILL;
    end
  end

  // State register; reset discards partial and pending words.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= FILL;
      slot   <= '0;
      part   <= '0;
      pmax   <= '0;
      pend_w <= '0;
      pend_m <= '0;
      out_v  <= 1'b0;
      out_w  <= '0;
      out_m  <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      slot   <= slot_n;
      part   <= part_n;
      pmax   <= pmax_n;
      pend_w <= pend_w_n;
      pend_m <= pend_m_n;
      out_v  <= out_v_n;
      out_w  <= out_w_n;
      out_m  <= out_m_n;
      cnt    <= cnt_n;
    end
  end

endmodule

// File: tb/tb_nibble_packer_4.sv
// Randomized and directed bench for nibble_packer_4.
// Reference model: queue of buffered words, capacity two.
module tb_nibble_packer_4;

  localparam int CW = 2;

  logic          CLK;
  logic          RESET;
  logic          IN_VALID;
  logic [3:0]    IN_NIBBLE;
  logic          IN_READY;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [15:0]   NIBBLES;
  logic [3:0]    NIBBLE_MAYOR;
  logic [CW-1:0] WORD_COUNT;

  nibble_packer_4 #(.COUNT_W(CW)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IN_VALID     (IN_VALID),
    .IN_NIBBLE    (IN_NIBBLE),
    .IN_READY     (IN_READY),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .NIBBLES      (NIBBLES),
    .NIBBLE_MAYOR (NIBBLE_MAYOR),
    .WORD_COUNT   (WORD_COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] wq[$];
  logic [3:0]  mq[$];
  int          nq[$];
  int          m_cnt;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    wq.delete();
    mq.delete();
    nq.delete();
    m_cnt = 0;
  endtask

  // Apply one cycle of inputs; check pre-edge outputs, then advance model.
  task automatic tick(input logic v, input logic [3:0] n,
                      input logic r);
    bit ix, ox;
    int w, mx;
    @(negedge CLK);
    IN_VALID  = v;
    IN_NIBBLE = n;
    OUT_READY = r;
    #1;
    check("in_ready", 32'(IN_READY), 32'(wq.size() < 2));
    check("out_valid", 32'(OUT_VALID), 32'(wq.size() > 0));
    check("word_count", 32'(WORD_COUNT), 32'(m_cnt));
    if (wq.size() > 0) begin
      check("nibbles", 32'(NIBBLES), 32'(wq[0]));
      check("mayor", 32'(NIBBLE_MAYOR), 32'(mq[0]));
    end
    ix = v && (wq.size() < 2);
    ox = r && (wq.size() > 0);
    @(posedge CLK);
    if (ox) begin
      void'(wq.pop_front());
      void'(mq.pop_front());
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    if (ix) begin
      nq.push_back(int'(n));
      if (nq.size() == 4) begin
        w  = 0;
        mx = 0;
        for (int i = 0; i < 4; i++) begin
          w = w + nq[i] * (1 << (4 * i));
          if (nq[i] > mx) mx = nq[i];
        end
        wq.push_back(16'(w));
        mq.push_back(4'(mx));
        nq.delete();
      end
    end
  endtask

  task automatic async_reset();
    @(negedge CLK);
    IN_VALID = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_nibbles", 32'(NIBBLES), 32'd0);
    check("rst_mayor", 32'(NIBBLE_MAYOR), 32'd0);
    check("rst_count", 32'(WORD_COUNT), 32'd0);
    check("rst_in_ready", 32'(IN_READY), 32'd0);
    model_clear();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic feed(input logic [3:0] n, input logic r);
    tick(1'b1, n, r);
  endtask

  initial begin
    RESET     = 1'b1;
    IN_VALID  = 1'b0;
    IN_NIBBLE = 4'h0;
    OUT_READY = 1'b0;
    model_clear();
    repeat (2) @(negedge CLK);
    #1;
    check("init_out_valid", 32'(OUT_VALID), 32'd0);
    check("init_nibbles", 32'(NIBBLES), 32'd0);
    check("init_mayor", 32'(NIBBLE_MAYOR), 32'd0);
    check("init_count", 32'(WORD_COUNT), 32'd0);
    check("init_in_ready", 32'(IN_READY), 32'd0);
    RESET = 1'b0;

    // First word with downstream always ready.
    feed(4'h3, 1'b1);
    feed(4'hA, 1'b1);
    feed(4'h1, 1'b1);
    feed(4'h7, 1'b1);
    tick(1'b0, 4'h0, 1'b1);
    tick(1'b0, 4'h0, 1'b1);

    // Stall: second word lands in pending, extra input ignored.
    feed(4'h1, 1'b0);
    feed(4'h2, 1'b0);
    feed(4'h3, 1'b0);
    feed(4'h4, 1'b0);
    feed(4'hF, 1'b0);
    feed(4'h0, 1'b0);
    feed(4'h0, 1'b0);
    feed(4'h0, 1'b0);
    feed(4'hC, 1'b0);
    feed(4'hD, 1'b0);
    tick(1'b0, 4'h0, 1'b1);
    tick(1'b0, 4'h0, 1'b0);
    tick(1'b0, 4'h0, 1'b1);
    tick(1'b0, 4'h0, 1'b1);

    // Back-to-back words at full cadence.
    for (int i = 0; i < 12; i++)
      feed((i == 11) ? 4'hF : 4'h0, 1'b1);
    tick(1'b0, 4'h0, 1'b1);
    tick(1'b0, 4'h0, 1'b1);

    // Gapped input stream of fives.
    for (int i = 0; i < 16; i++)
      tick(1'($urandom_range(0, 1)), 4'h5, 1'b1);
    repeat (2) tick(1'b0, 4'h0, 1'b1);

    // Reset mid-word, then a fresh word.
    feed(4'h2, 1'b1);
    feed(4'h4, 1'b1);
    async_reset();
    feed(4'h9, 1'b1);
    feed(4'h8, 1'b1);
    feed(4'h7, 1'b1);
    feed(4'h6, 1'b1);
    tick(1'b0, 4'h0, 1'b1);

    // Reset while FULL.
    for (int i = 0; i < 8; i++)
      feed(4'(i + 1), 1'b0);
    tick(1'b0, 4'h0, 1'b0);
    async_reset();
    feed(4'h9, 1'b1);
    feed(4'h8, 1'b1);
    feed(4'h7, 1'b1);
    feed(4'h6, 1'b1);
    tick(1'b0, 4'h0, 1'b1);

    // Five words to wrap the 2-bit counter.
    for (int i = 0; i < 20; i++)
      feed(4'($urandom_range(0, 15)), 1'b1);
    repeat (2) tick(1'b0, 4'h0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0)
        async_reset();
      else
        tick(1'($urandom_range(0, 9) < 7),
             4'($urandom_range(0, 15)),
             1'($urandom_range(0, 9) < ((i < 400) ? 3 : 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
